// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice walks LSB-first across WIDTH bits, with a valid/ready request and result handshake.
// Define SERIAL_ADDER_CTRL_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               out_valid_q, out_valid_d;
    logic               s_bit, c_bit;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    // Next-state and datapath update; everything holds unless a branch changes it.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    sum_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    carry_d     = 1'b0;
                end else begin
                    sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                    a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_d = c_bit;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at its last value so it never wraps.
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        cout_d      = c_bit;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
                        ovf_d       = carry_q ^ c_bit;
`endif
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    carry_d     = 1'b0;
                end else if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SERIAL_ADDER_CTRL_OVF_EN
    // Overflow flag, captured alongside cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus random traffic against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, flush, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    logic         ovf_s;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ,
        .ovf       (ovf_s)
`endif
    );
`ifndef SERIAL_ADDER_CTRL_OVF_EN
    assign ovf_s = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: phase 0 idle, 1 computing (WIDTH edges), 2 result held; result is plain addition.
    int           m_phase;
    int           m_left;
    logic [W:0]   m_res;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_res   <= '0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_left  <= W;
                m_res   <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_ovf   <= (((({1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin}) >> (W-1)) & 1) != 0)
                           ^ ((({2'b0, a} + {2'b0, b} + {{(W+1){1'b0}}, cin}) >> W) & 1) != 0;
            end
        end else if (m_phase == 1) begin
            if (flush) m_phase <= 0;
            else if (m_left == 1) m_phase <= 2;
            else m_left <= m_left - 1;
        end else begin
            if (flush || out_ready) m_phase <= 0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, (m_phase == 0)});
            chk("busy", {63'd0, busy}, {63'd0, (m_phase != 0)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, (m_phase == 2)});
            if (m_phase == 2) begin
                chk("sum", {56'd0, sum}, {56'd0, m_res[W-1:0]});
                chk("cout", {63'd0, cout}, {63'd0, m_res[W]});
`ifdef SERIAL_ADDER_CTRL_OVF_EN
                chk("ovf", {63'd0, ovf_s}, {63'd0, m_ovf});
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input int bp,
                          output logic [W-1:0] rs, output logic rc, output logic ro, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; flush = 1'b0; out_ready = (bp == 0);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b1;
        chk("in_ready_fall", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (bp) @(negedge clk);
        chk("in_ready_done", {63'd0, in_ready}, 64'd0);
        rs = sum; rc = cout; ro = ovf_s;
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_back", {63'd0, in_ready}, 64'd1);
    endtask

    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sum", {56'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 0, rs, rc, ro, lat);
        chk("lat_5a3c", 64'(lat), 64'd8);
        chk("sum_5a3c", {56'd0, rs}, 64'h96);
        chk("cout_5a3c", {63'd0, rc}, 64'd0);
        run_op(8'hFF, 8'h01, 1'b0, 0, rs, rc, ro, lat);
        chk("sum_ff01", {56'd0, rs}, 64'h00);
        chk("cout_ff01", {63'd0, rc}, 64'd1);
        run_op(8'hFF, 8'h00, 1'b1, 0, rs, rc, ro, lat);
        chk("sum_ff00c", {56'd0, rs}, 64'h00);
        chk("cout_ff00c", {63'd0, rc}, 64'd1);
        run_op(8'hFF, 8'hFF, 1'b1, 0, rs, rc, ro, lat);
        chk("sum_ffffc", {56'd0, rs}, 64'hFF);
        chk("cout_ffffc", {63'd0, rc}, 64'd1);
        run_op(8'h12, 8'h34, 1'b0, 5, rs, rc, ro, lat);
        chk("sum_bp", {56'd0, rs}, 64'h46);
        chk("cout_bp", {63'd0, rc}, 64'd0);

        // Flush once the counter has reached 3.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (10) @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, 0, rs, rc, ro, lat);
        chk("sum_after_flush", {56'd0, rs}, 64'h02);

        // Asynchronous reset between edges during RUN.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_sum", {56'd0, sum}, 64'd0);
        chk("arst_cout", {63'd0, cout}, 64'd0);
        #1 rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 0, rs, rc, ro, lat);
        chk("sum_after_rst", {56'd0, rs}, 64'h10);

`ifdef SERIAL_ADDER_CTRL_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0, rs, rc, ro, lat);
        chk("sum_7f01", {56'd0, rs}, 64'h80);
        chk("cout_7f01", {63'd0, rc}, 64'd0);
        chk("ovf_7f01", {63'd0, ro}, 64'd1);
        run_op(8'h80, 8'h80, 1'b0, 0, rs, rc, ro, lat);
        chk("sum_8080", {56'd0, rs}, 64'h00);
        chk("cout_8080", {63'd0, rc}, 64'd1);
        chk("ovf_8080", {63'd0, ro}, 64'd1);
        run_op(8'hFF, 8'h01, 1'b0, 0, rs, rc, ro, lat);
        chk("ovf_ff01", {63'd0, ro}, 64'd0);
`endif

        // Random traffic, including flush in every state and backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
